// File: rtl/filt_dec_rnd_pkg.sv
// Shared helpers for the decimating round/saturate stage: sizing functions
// evaluated at elaboration time only.
package filt_dec_rnd_pkg;

  // Phase counter width; a decimation factor of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Bit position of the rounding half-LSB; clamped so a zero shift stays legal.
  function automatic int half_pos(input int shift);
    return (shift > 0) ? shift - 1 : 0;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled register bank with asynchronous active-low reset.
module dff #(
  parameter int gp_width = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_d,
  output logic [gp_width-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_q <= '0;
    end else if (i_ena) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/filt_dec_rnd.sv
// Decimate-by-M, round (or truncate), shift and saturate the FIR output.
// Two register stages: stage 1 holds the rounded sum, stage 2 the saturated result.
module filt_dec_rnd
  import filt_dec_rnd_pkg::*;
#(
  parameter int gp_inp_width  = 21,
  parameter int gp_oup_width  = 8,
  parameter int gp_shift      = 13,
  parameter int gp_dec_factor = 4,
  parameter int gp_phase      = 0,
  parameter int gp_rnd        = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_an,
  input  logic                           i_ena,
  input  logic                           i_sync,
  input  logic                           i_ovf_clr,
  input  logic signed [gp_inp_width-1:0] i_data,
  output logic signed [gp_oup_width-1:0] o_data,
  output logic                           o_valid,
  output logic                           o_ovf
);

  // One guard bit above the input absorbs the rounding carry.
  localparam int lp_gw = gp_inp_width + 1;
  localparam int lp_cw = cnt_width(gp_dec_factor);

  localparam logic [lp_cw-1:0] lp_last    = lp_cw'(gp_dec_factor - 1);
  localparam logic [lp_cw-1:0] lp_phase   = lp_cw'(gp_phase);
  localparam logic [lp_cw-1:0] lp_one     = lp_cw'(1);
  localparam logic [lp_cw-1:0] lp_sync_ld = (gp_dec_factor == 1) ? '0 : lp_one;

  localparam logic [lp_gw-1:0] lp_half =
    (gp_rnd != 0 && gp_shift > 0) ? ({{(lp_gw-1){1'b0}}, 1'b1} << half_pos(gp_shift)) : '0;

  localparam logic signed [lp_gw-1:0] lp_max =
    {{(lp_gw-gp_oup_width){1'b0}}, 1'b0, {(gp_oup_width-1){1'b1}}};
  localparam logic signed [lp_gw-1:0] lp_min =
    {{(lp_gw-gp_oup_width){1'b1}}, 1'b1, {(gp_oup_width-1){1'b0}}};

  logic [lp_cw-1:0]        cnt_q, cnt_d;
  logic [lp_cw-1:0]        eff_phase;
  logic                    accept;
  logic                    v1_q, v2_q;
  logic                    ovf_q, ovf_d;
  logic [lp_gw-1:0]        s1_d, s1_q;
  logic signed [lp_gw-1:0] shifted;
  logic                    sat_hi, sat_lo;
  logic [gp_oup_width-1:0] s2_d, s2_q;

  // Sync forces the effective phase to 0 so the syncing sample lands on phase 0.
  always_comb begin
    eff_phase = i_sync ? '0 : cnt_q;
    accept    = i_ena && (eff_phase == lp_phase);
    cnt_d     = cnt_q;
    if (i_sync) begin
      cnt_d = i_ena ? lp_sync_ld : '0;
    end else if (i_ena) begin
      cnt_d = (cnt_q == lp_last) ? '0 : cnt_q + lp_one;
    end
  end

  always_comb begin
    s1_d = {i_data[gp_inp_width-1], i_data} + lp_half;
  end

  dff #(.gp_width(lp_gw)) u_stage1 (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (accept),
    .i_d      (s1_d),
    .o_q      (s1_q)
  );

  always_comb begin
    shifted = $signed(s1_q) >>> gp_shift;
    sat_hi  = (shifted > lp_max);
    sat_lo  = (shifted < lp_min);
    if (sat_hi) begin
      s2_d = lp_max[gp_oup_width-1:0];
    end else if (sat_lo) begin
      s2_d = lp_min[gp_oup_width-1:0];
    end else begin
      s2_d = shifted[gp_oup_width-1:0];
    end
    // A new saturation wins over a simultaneous clear.
    ovf_d = (v1_q && (sat_hi || sat_lo)) || (ovf_q && !i_ovf_clr);
  end

  dff #(.gp_width(gp_oup_width)) u_stage2 (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (v1_q),
    .i_d      (s2_d),
    .o_q      (s2_q)
  );

  // Valid bits move every cycle regardless of i_ena so in-flight samples drain.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      v1_q  <= accept;
      v2_q  <= v1_q;
      ovf_q <= ovf_d;
    end
  end

  // o_valid is a one-cycle strobe per output sample; there is no backpressure.
  assign o_data  = s2_q;
  assign o_valid = v2_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_filt_dec_rnd.sv
// Directed bench for filt_dec_rnd: rounding, saturation, decimation, sync,
// truncation and reset behaviour on three parameterisations.
module tb_filt_dec_rnd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // M=1, rounding
  logic               a_ena, a_sync, a_clr;
  logic signed [20:0] a_data;
  logic signed [7:0]  a_o_data;
  logic               a_o_valid, a_o_ovf;
  // M=4, rounding
  logic               b_ena, b_sync, b_clr;
  logic signed [20:0] b_data;
  logic signed [7:0]  b_o_data;
  logic               b_o_valid, b_o_ovf;
  // M=1, truncate
  logic               c_ena, c_sync, c_clr;
  logic signed [20:0] c_data;
  logic signed [7:0]  c_o_data;
  logic               c_o_valid, c_o_ovf;

  filt_dec_rnd #(.gp_dec_factor(1)) u_a (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(a_ena), .i_sync(a_sync), .i_ovf_clr(a_clr),
    .i_data(a_data), .o_data(a_o_data), .o_valid(a_o_valid), .o_ovf(a_o_ovf)
  );
  filt_dec_rnd u_b (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(b_ena), .i_sync(b_sync), .i_ovf_clr(b_clr),
    .i_data(b_data), .o_data(b_o_data), .o_valid(b_o_valid), .o_ovf(b_o_ovf)
  );
  filt_dec_rnd #(.gp_dec_factor(1), .gp_rnd(0)) u_c (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(c_ena), .i_sync(c_sync), .i_ovf_clr(c_clr),
    .i_data(c_data), .o_data(c_o_data), .o_valid(c_o_valid), .o_ovf(c_o_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  int rnd_in  [5] = '{4096, 8191, 12288, -4096, -4097};
  int rnd_exp [5] = '{1, 1, 2, 0, -1};
  int trc_in  [3] = '{8191, -1, 24575};
  int trc_exp [3] = '{0, -1, 2};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sync_acc(input int k);
    return (k == 0) || (k == 4) || (k == 5) || (k == 9);
  endfunction

  initial begin
    int last;
    int p;
    bit ev;
    rst_n = 1'b0;
    a_ena = 0; a_sync = 0; a_clr = 0; a_data = '0;
    b_ena = 0; b_sync = 0; b_clr = 0; b_data = '0;
    c_ena = 0; c_sync = 0; c_clr = 0; c_data = '0;
    tick();
    tick();
    chk("rst_a_data",  int'(a_o_data), 0);
    chk("rst_a_valid", int'(a_o_valid), 0);
    chk("rst_a_ovf",   int'(a_o_ovf), 0);
    chk("rst_b_data",  int'(b_o_data), 0);
    chk("rst_b_valid", int'(b_o_valid), 0);
    chk("rst_c_valid", int'(c_o_valid), 0);
    rst_n = 1'b1;

    // Rounding, M=1, back-to-back: o_valid stays high for the whole burst
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin a_ena = 1; a_data = 21'(rnd_in[i]); end
      else a_ena = 0;
      tick();
      if (i >= 1) begin
        chk("rnd_valid", int'(a_o_valid), 1);
        chk("rnd_data",  int'(a_o_data), rnd_exp[i-1]);
        chk("rnd_ovf",   int'(a_o_ovf), 0);
      end else begin
        chk("rnd_lat_valid", int'(a_o_valid), 0);
      end
    end
    tick();
    chk("rnd_end_valid", int'(a_o_valid), 0);
    chk("rnd_hold_data", int'(a_o_data), -1);

    // Saturation and sticky overflow
    a_ena = 1; a_data = 21'(1044480);
    tick();
    a_data = 21'(-1048576);
    tick();
    chk("sat_hi_valid", int'(a_o_valid), 1);
    chk("sat_hi_data",  int'(a_o_data), 127);
    chk("sat_hi_ovf",   int'(a_o_ovf), 1);
    a_ena = 0;
    tick();
    chk("sat_lo_data", int'(a_o_data), -128);
    chk("sat_lo_ovf",  int'(a_o_ovf), 1);
    tick();
    chk("sat_hold_valid", int'(a_o_valid), 0);
    chk("sat_hold_data",  int'(a_o_data), -128);
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("ovf_clr", int'(a_o_ovf), 0);
    a_ena = 1; a_data = 21'(1044480);
    tick();
    a_ena = 0; a_clr = 1;
    tick();
    a_clr = 0;
    chk("ovf_set_wins", int'(a_o_ovf), 1);
    chk("ovf_set_data", int'(a_o_data), 127);

    // Decimation by 4, phase 0, continuous enable, data k*8192 -> k
    last = 0;
    for (int i = 0; i <= 17; i++) begin
      if (i < 16) begin b_ena = 1; b_data = 21'(i * 8192); end
      else b_ena = 0;
      tick();
      p  = i - 1;
      ev = (i >= 1) && (p < 16) && (p % 4 == 0);
      chk("dec_valid", int'(b_o_valid), int'(ev));
      if (ev) last = p;
      chk("dec_data", int'(b_o_data), last);
    end

    // Gated enable (1/0 toggle) with a sync on enabled sample 5
    for (int i = 0; i <= 22; i++) begin
      if (i < 22) begin
        b_ena  = (i % 2 == 0);
        b_sync = (i == 10);
        b_data = 21'((i / 2) * 8192);
      end else begin
        b_ena = 0; b_sync = 0;
      end
      tick();
      if (i >= 1) begin
        p  = i - 1;
        ev = (p % 2 == 0) && sync_acc(p / 2);
        chk("sync_valid", int'(b_o_valid), int'(ev));
        if (ev) last = p / 2;
        chk("sync_data", int'(b_o_data), last);
      end
    end

    // Truncate mode
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin c_ena = 1; c_data = 21'(trc_in[i]); end
      else c_ena = 0;
      tick();
      if (i >= 1) begin
        chk("trc_valid", int'(c_o_valid), 1);
        chk("trc_data",  int'(c_o_data), trc_exp[i-1]);
      end
    end

    // Reset while a sample sits in stage 1
    a_ena = 1; a_data = 21'(4096);
    tick();
    a_ena = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_data",  int'(a_o_data), 0);
    chk("arst_a_valid", int'(a_o_valid), 0);
    chk("arst_a_ovf",   int'(a_o_ovf), 0);
    chk("arst_b_data",  int'(b_o_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", int'(a_o_valid), 0);
      chk("post_rst_data",  int'(a_o_data), 0);
    end
    a_ena = 1; a_data = 21'(12288);
    tick();
    a_ena = 0;
    tick();
    chk("restart_valid", int'(a_o_valid), 1);
    chk("restart_data",  int'(a_o_data), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filt_dec_rnd.md
FILT_DEC_RND -- requirements
Module: filt_dec_rnd

Interface
REQ-001 The block SHALL have parameter gp_inp_width, default 21, meaning signed input width (the FIR output width 8+8+clog2(17)).
REQ-002 The block SHALL have parameter gp_oup_width, default 8, meaning signed output width.
REQ-003 The block SHALL have parameter gp_shift, default 13, meaning number of LSBs discarded; legal range 0..gp_inp_width-1.
REQ-004 The block SHALL have parameter gp_dec_factor, default 4, meaning decimation ratio M, legal range >=1.
REQ-005 The block SHALL have parameter gp_phase, default 0, meaning which counter value 0..M-1 is kept.
REQ-006 The block SHALL have parameter gp_rnd, default 1, meaning 1 selects round-half-up and 0 selects truncate.
REQ-007 The block SHALL have port i_clk, input, 1 bit, the single clock, all logic on its rising edge.
REQ-008 The block SHALL have port i_rst_an, input, 1 bit; reset is asynchronous and active-low.
REQ-009 The block SHALL have port i_ena, input, 1 bit, meaning an input sample is present this cycle.
REQ-010 The block SHALL have port i_sync, input, 1 bit, meaning a synchronous phase restart.
REQ-011 The block SHALL have port i_ovf_clr, input, 1 bit, meaning a synchronous clear of the sticky overflow flag.
REQ-012 The block SHALL have port i_data, input, signed gp_inp_width bits, the FIR output.
REQ-013 The block SHALL have port o_data, output, signed gp_oup_width bits, the decimated, rounded and saturated sample.
REQ-014 The block SHALL have port o_valid, output, 1 bit, a one-cycle strobe marking a new o_data.
REQ-015 The block SHALL have port o_ovf, output, 1 bit, a sticky flag set whenever an output was saturated.

Function
REQ-016 The phase counter SHALL count 0..M-1, advance only on i_ena=1 and wrap from M-1 to 0.
REQ-017 A sample SHALL be accepted when i_ena=1 and the effective phase equals gp_phase; the effective phase is 0 when i_sync=1, otherwise the counter value.
REQ-018 When i_sync=1 and i_ena=1, the counter SHALL load 1 (0 if M=1); when i_sync=1 and i_ena=0, it SHALL load 0.
REQ-019 Stage 1 SHALL register the value i_data + 2^(gp_shift-1) at gp_inp_width+1 bits when gp_rnd=1 and gp_shift>0; otherwise it SHALL register i_data sign-extended.
REQ-020 Stage 2 SHALL arithmetic-right-shift the stage-1 value by gp_shift and saturate it to [-2^(gp_oup_width-1), 2^(gp_oup_width-1)-1] before registering it to o_data.
REQ-021 o_data SHALL update and o_valid SHALL pulse high exactly 2 i_clk cycles after the accepting edge; o_data SHALL hold its value between strobes.
REQ-022 The pipeline SHALL drain regardless of i_ena: in-flight samples complete even when i_ena falls.
REQ-023 With M=1 and back-to-back i_ena, the block SHALL produce one output per cycle with o_valid held continuously high.
REQ-024 o_ovf SHALL set on the cycle o_valid asserts with a saturated value, and SHALL clear on i_ovf_clr=1; a simultaneous set and clear SHALL result in set.
REQ-025 The arithmetic SHALL never overflow internally; the +1 guard bit absorbs the rounding carry.

Reset
REQ-026 While i_rst_an=0, the block SHALL force the counter=0, both stage registers and their valid bits=0, o_data=0, o_valid=0 and o_ovf=0, independent of i_clk.
REQ-027 Reset asserted mid-operation SHALL discard in-flight samples, and no o_valid SHALL appear for them after release.
REQ-028 The first accepting edge after release SHALL be the first i_ena=1 cycle whose effective phase equals gp_phase.

Structure
REQ-029 No package is required; the localparam set (guard width, saturation limits) SHALL live in the module, and the `DIV macro in the shared include file SHALL be reused if needed.
REQ-030 The two pipeline stages SHALL be built from the existing dff sub-module (async active-low reset, enable = stage valid-in), with widths gp_inp_width+1 and gp_oup_width.
REQ-031 The module SHALL instantiate directly downstream of filt_fir: i_data connects to its o_data and both share i_clk, i_rst_an and i_ena.

Verification (defaults unless stated)
REQ-032 Rounding: M=1, inputs 4096, 8191, 12288, -4096, -4097 -> o_data 1, 1, 2, 0, -1, each 2 cycles later, o_ovf=0.
REQ-033 Saturation: inputs 1044480 then -1048576 -> o_data 127 with o_ovf=1, then -128; i_ovf_clr pulse -> o_ovf=0; a clear coinciding with a new saturation -> o_ovf stays 1.
REQ-034 Decimation: M=4, gp_phase=0, i_ena continuous, i_data=k*8192 for k=0..15 -> o_data 0, 4, 8, 12 with o_valid pulsing every 4 cycles.
REQ-035 Sync and gated enable: i_ena toggling 1/0, then i_sync at input k=5 -> k=5 output, next output at the 4th subsequent enabled sample, and no output on i_ena=0 cycles.
REQ-036 Reset mid-pipeline: assert i_rst_an low 1 cycle after an accepted sample -> o_valid never pulses, and all outputs read 0 asynchronously.
REQ-037 Truncate mode: gp_rnd=0, M=1, inputs 8191 and -1 -> o_data 0 and -1.
